// File: rtl/bcd_convert_param.sv
// Sequential binary-to-BCD converter (double dabble) with start/busy/done handshake.
// Define BCD_CONVERT_SIGNED_EN to treat bin_in as two's complement and report the sign on neg.
module bcd_convert_param #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  neg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (BIN_W > 2) ? $clog2(BIN_W) : 1;

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [BcdW-1:0]   scratch_q;
  logic              ovf_scr_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q, ovf_q;
  logic [BcdW-1:0]   bcd_q;

  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   scr_next;
  logic [BIN_W-1:0]  shift_next;
  logic              carry;
  logic [BIN_W-1:0]  load_val;

  // Add-3 is confined to each nibble; the following shift carries into the next digit.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scratch_q[4*d +: 4] > 4'd4) adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  assign {carry, scr_next, shift_next} = {adj, shift_q, 1'b0};

`ifdef BCD_CONVERT_SIGNED_EN
  logic neg_hold_q, neg_q;
  // Most-negative input wraps to itself, which read unsigned is the correct magnitude.
  assign load_val = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
  assign neg      = neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_hold_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && start) neg_hold_q <= bin_in[BIN_W-1];
      if (state_q == StConvert && cnt_q == '0) neg_q <= neg_hold_q;
    end
  end
`else
  assign load_val = bin_in;
  assign neg      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_scr_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q   <= load_val;
            scratch_q <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= CntW'(BIN_W - 1);
            busy_q    <= 1'b1;
            state_q   <= StConvert;
          end
        end
        StConvert: begin
          scratch_q <= scr_next;
          shift_q   <= shift_next;
          ovf_scr_q <= ovf_scr_q | carry;
          if (cnt_q == '0) begin
            bcd_q   <= scr_next;
            ovf_q   <= ovf_scr_q | carry;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
